// File: rtl/odd_parity_pkg.sv
// Shared types and helpers for the odd-parity serial link (transmitter and receiver side).
package odd_parity_pkg;

  localparam int unsigned DATA_W_DEFAULT = 16;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  function automatic logic odd_parity(input logic [15:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/odd_parity_gen.sv
// Combinational odd-parity generator: parity makes the total count of ones odd.
module odd_parity_gen #(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0] data,
  output logic              parity
);

  assign parity = ~^data;

endmodule

// File: rtl/odd_parity_serial_tx.sv
// Framed serial transmitter: start, DATA_W bits LSB-first, odd parity, stop.
// Optional parity error injection is compiled in with PARITY_ERR_INJECT_EN.
module odd_parity_serial_tx
  import odd_parity_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEFAULT,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
`ifdef PARITY_ERR_INJECT_EN
  input  logic              inject_err,
`endif
  output logic              data_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              parity_out
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned IdxW = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_W - 1);

  tx_state_e         state_q;
  logic [CntW-1:0]   bit_cnt_q;
  logic [IdxW-1:0]   bit_idx_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_nxt;
  logic              par_raw;
  logic              par_new;
  logic              accept;
  logic              bit_done;

  odd_parity_gen #(
    .DATA_W (DATA_W)
  ) u_parity_gen (
    .data   (data_in),
    .parity (par_raw)
  );

`ifdef PARITY_ERR_INJECT_EN
  assign par_new = par_raw ^ inject_err;
`else
  assign par_new = par_raw;
`endif

  assign accept    = data_valid && data_ready;
  assign bit_done  = (bit_cnt_q == CntLast);
  assign shift_nxt = shift_q >> 1;

  // tx_out is registered one state ahead so the line changes on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_out     <= 1'b1;
      data_ready <= 1'b1;
      busy       <= 1'b0;
      parity_out <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            shift_q    <= data_in;
            parity_out <= par_new;
            data_ready <= 1'b0;
            busy       <= 1'b1;
            tx_out     <= 1'b0;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            state_q    <= StStart;
          end
        end
        StStart: begin
          if (bit_done) begin
            bit_cnt_q <= '0;
            tx_out    <= shift_q[0];
            state_q   <= StData;
          end else begin
            bit_cnt_q <= bit_cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (bit_done) begin
            bit_cnt_q <= '0;
            shift_q   <= shift_nxt;
            if (bit_idx_q == IdxLast) begin
              bit_idx_q <= '0;
              tx_out    <= parity_out;
              state_q   <= StParity;
            end else begin
              bit_idx_q <= bit_idx_q + IdxW'(1);
              tx_out    <= shift_nxt[0];
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + CntW'(1);
          end
        end
        StParity: begin
          if (bit_done) begin
            bit_cnt_q <= '0;
            tx_out    <= 1'b1;
            state_q   <= StStop;
          end else begin
            bit_cnt_q <= bit_cnt_q + CntW'(1);
          end
        end
        StStop: begin
          if (bit_done) begin
            bit_cnt_q  <= '0;
            data_ready <= 1'b1;
            busy       <= 1'b0;
            tx_out     <= 1'b1;
            state_q    <= StIdle;
          end else begin
            bit_cnt_q <= bit_cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q    <= StIdle;
          bit_cnt_q  <= '0;
          bit_idx_q  <= '0;
          tx_out     <= 1'b1;
          data_ready <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_odd_parity_serial_tx.sv
// Directed self-checking bench for odd_parity_serial_tx at default parameters.
// Define PARITY_ERR_INJECT_EN to also exercise the parity error injection path.
module tb_odd_parity_serial_tx;

  logic        clk;
  logic        rst_n;
  logic [15:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic        tx_out;
  logic        busy;
  logic        parity_out;
`ifdef PARITY_ERR_INJECT_EN
  logic        inject_err;
`endif

  int n_tests;
  int n_fail;

  odd_parity_serial_tx #(
    .DATA_W       (16),
    .CLKS_PER_BIT (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .data_valid (data_valid),
`ifdef PARITY_ERR_INJECT_EN
    .inject_err (inject_err),
`endif
    .data_ready (data_ready),
    .tx_out     (tx_out),
    .busy       (busy),
    .parity_out (parity_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge in a ready cycle; returns at the negedge of the first ready cycle after.
  task automatic send_frame(input logic [15:0] d, input logic p, input logic inj,
                            input bit wiggle);
    logic [18:0] exp_bits;
    logic [18:0] cap;
    exp_bits = {1'b1, p, d, 1'b0};
    cap      = '0;
    check_eq("ready_pre", data_ready, 1);
    check_eq("line_pre", tx_out, 1);
    data_in    = d;
    data_valid = 1'b1;
`ifdef PARITY_ERR_INJECT_EN
    inject_err = inj;
`endif
    @(negedge clk);
    data_valid = 1'b0;
`ifdef PARITY_ERR_INJECT_EN
    inject_err = 1'b0;
`endif
    check_eq("parity_out", parity_out, p);
    for (int k = 0; k < 76; k++) begin
      check_eq($sformatf("line_bit%0d", k / 4), tx_out, exp_bits[k/4]);
      check_eq("busy_frame", busy, 1);
      check_eq("ready_frame", data_ready, 0);
      if (k % 4 == 2) cap[k/4] = tx_out;
      if (wiggle) begin
        data_valid = 1'($urandom_range(0, 1));
        data_in    = 16'($urandom);
      end
      @(negedge clk);
    end
    data_valid = 1'b0;
    check_eq("ready_post", data_ready, 1);
    check_eq("busy_post", busy, 0);
    check_eq("line_post", tx_out, 1);
    check_eq("parity_hold", parity_out, p);
    check_eq("checker_pass", ^cap[17:1], !inj);
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    data_in    = '0;
    data_valid = 1'b0;
`ifdef PARITY_ERR_INJECT_EN
    inject_err = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_eq("rst_parity", parity_out, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("idle_line", tx_out, 1);
      check_eq("idle_ready", data_ready, 1);
      check_eq("idle_busy", busy, 0);
    end

    send_frame(16'h0000, 1'b1, 1'b0, 1'b0);

    // Back-to-back: each frame starts in the first ready cycle after the previous one.
    send_frame(16'h0001, 1'b0, 1'b0, 1'b0);
    send_frame(16'hFFFF, 1'b1, 1'b0, 1'b0);
    send_frame(16'h8001, 1'b1, 1'b0, 1'b0);
    send_frame(16'hA5A5, 1'b1, 1'b0, 1'b0);

    // Inputs wiggling mid-frame must not disturb the line.
    send_frame(16'h00F0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("post_wiggle_line", tx_out, 1);
      check_eq("post_wiggle_busy", busy, 0);
    end

    // Abort 0x1234 during data bit 7 with an asynchronous reset.
    data_in    = 16'h1234;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (33) @(negedge clk);
    check_eq("abort_bit7", tx_out, 0);
    check_eq("abort_busy_pre", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_line", tx_out, 1);
    check_eq("abort_ready", data_ready, 1);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_parity", parity_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(16'h0003, 1'b1, 1'b0, 1'b0);

`ifdef PARITY_ERR_INJECT_EN
    send_frame(16'h0000, 1'b0, 1'b1, 1'b0);
    send_frame(16'h0000, 1'b1, 1'b0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
